// File: rtl/vend_pkg.sv
// Package: vend_pkg
// Shared state encoding, coin constants and price-table helper for the
// vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  // The only coin denominations the front-end may present.
  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_10 = 6'd10;
  localparam logic [5:0] COIN_20 = 6'd20;

  // Upper bounds for the generic price-field extractor.
  localparam int PRICE_TBL_W   = 256;
  localparam int PRICE_FIELD_W = 32;

  // Returns field 'idx' of width 'w' from a flat, little-endian price table.
  function automatic logic [PRICE_FIELD_W-1:0] price_field(
    input logic [PRICE_TBL_W-1:0] tbl,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [PRICE_FIELD_W-1:0] mask;
    mask = (PRICE_FIELD_W'(1) << w) - PRICE_FIELD_W'(1);
    return PRICE_FIELD_W'(tbl >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/vend_coin_check.sv
// Module: vend_coin_check
// Combinational check of one coin: legal denomination and no credit overflow.
// The sum is formed one bit wider than the credit so it can never wrap.
module vend_coin_check
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100
) (
  input  logic [5:0]          coin_val,
  input  logic [CREDIT_W-1:0] credit,
  output logic                coin_ok,
  output logic [CREDIT_W-1:0] coin_sum
);

  localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

  logic              legal;
  logic [CREDIT_W:0] sum_ext;

  // Legality, widened sum and ceiling compare.
  always_comb begin
    legal    = (coin_val == COIN_5) || (coin_val == COIN_10) || (coin_val == COIN_20);
    sum_ext  = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
    coin_ok  = legal && (sum_ext <= MAX_EXT);
    coin_sum = sum_ext[CREDIT_W-1:0];
  end

endmodule

// File: rtl/vend_sequencer.sv
// Module: vend_sequencer
// Vending transaction controller: accumulates coin credit, validates a
// selection against price/stock, runs the dispense handshake and then the
// change handshake. All outputs are registered.
// Optional feature: define VEND_TIMEOUT_EN to refund credit automatically
// after TIMEOUT_CYC consecutive cycles without coin/selection/cancel activity.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int                         NUM_PROD    = 4,
  parameter int                         CREDIT_W    = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_VEC = 32'h140F0A05,
  parameter int                         MAX_CREDIT  = 100,
  parameter int                         TIMEOUT_CYC = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_vld,
  input  logic [5:0]                  coin_val,
  output logic                        coin_rej,
  input  logic                        sel_vld,
  input  logic [$clog2(NUM_PROD)-1:0] sel_id,
  output logic                        sel_err,
  input  logic                        cancel,
  input  logic [NUM_PROD-1:0]         empty,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        disp_req,
  output logic [$clog2(NUM_PROD)-1:0] disp_id,
  input  logic                        disp_ack,
  output logic                        chg_req,
  output logic [CREDIT_W-1:0]         chg_amt,
  input  logic                        chg_ack,
  output logic                        busy
);

  localparam int SEL_W = $clog2(NUM_PROD);

  // Reject impossible configurations at elaboration.
  if (TIMEOUT_CYC < 1 || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_param_err
    $error("vend_sequencer: TIMEOUT_CYC must be >= 1 and MAX_CREDIT must fit CREDIT_W");
  end

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit_d, chg_amt_d, coin_sum, price_sel;
  logic [SEL_W-1:0]    disp_id_d;
  logic                coin_rej_d, sel_err_d, disp_req_d, chg_req_d, busy_d;
  logic                coin_ok, sel_ok, tmo_fire;

  vend_coin_check #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_coin_check (
    .coin_val (coin_val),
    .credit   (credit),
    .coin_ok  (coin_ok),
    .coin_sum (coin_sum)
  );

  assign price_sel = CREDIT_W'(price_field(PRICE_TBL_W'(PRICE_VEC), 32'(sel_id), CREDIT_W));
  assign sel_ok    = (32'(sel_id) < 32'(NUM_PROD)) && !empty[sel_id] && (credit >= price_sel);

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             activity;

  assign activity = coin_vld || sel_vld || cancel;
  assign tmo_fire = (state == ST_CREDIT) && !activity &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Inactivity counter: only counts quiet cycles while holding credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if ((state != ST_CREDIT) || activity || tmo_fire)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Next-state and next-output logic; priority in CREDIT is
  // cancel/timeout > valid selection > coin.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d    = state;
    credit_d   = credit;
    disp_req_d = disp_req;
    disp_id_d  = disp_id;
    chg_req_d  = chg_req;
    chg_amt_d  = chg_amt;
    coin_rej_d = 1'b0;
    sel_err_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (coin_vld) begin
          if (coin_ok) begin
            credit_d = coin_sum;
            state_d  = ST_CREDIT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
        sel_err_d = sel_vld;
      end

      ST_CREDIT: begin
        if (cancel || tmo_fire) begin
          chg_amt_d  = credit;
          chg_req_d  = 1'b1;
          credit_d   = '0;
          coin_rej_d = coin_vld;
          state_d    = ST_CHANGE;
        end else if (sel_vld && sel_ok) begin
          credit_d   = credit - price_sel;
          disp_id_d  = sel_id;
          disp_req_d = 1'b1;
          coin_rej_d = coin_vld;
          state_d    = ST_DISPENSE;
        end else begin
          // Refused selection still lets a coincident coin through.
          sel_err_d = sel_vld;
          if (coin_vld) begin
            if (coin_ok) credit_d   = coin_sum;
            else         coin_rej_d = 1'b1;
          end
        end
      end

      ST_DISPENSE: begin
        coin_rej_d = coin_vld;
        if (disp_ack) begin
          disp_req_d = 1'b0;
          if (credit != '0) begin
            chg_amt_d = credit;
            chg_req_d = 1'b1;
            credit_d  = '0;
            state_d   = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        coin_rej_d = coin_vld;
        if (chg_ack) begin
          chg_req_d = 1'b0;
          chg_amt_d = '0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= ST_IDLE;
      credit   <= '0;
      coin_rej <= 1'b0;
      sel_err  <= 1'b0;
      disp_req <= 1'b0;
      disp_id  <= '0;
      chg_req  <= 1'b0;
      chg_amt  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      credit   <= credit_d;
      coin_rej <= coin_rej_d;
      sel_err  <= sel_err_d;
      disp_req <= disp_req_d;
      disp_id  <= disp_id_d;
      chg_req  <= chg_req_d;
      chg_amt  <= chg_amt_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Testbench: tb_vend_sequencer
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a transaction-level reference model of the vending rules.
module tb_vend_sequencer;

  localparam int NUM_PROD   = 4;
  localparam int CREDIT_W   = 8;
  localparam int MAX_CREDIT = 100;
  localparam int TMO        = 16;

  typedef enum {P_WAIT, P_HAVE, P_VEND, P_REFUND} phase_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                coin_vld = 1'b0;
  logic [5:0]          coin_val = '0;
  logic                coin_rej;
  logic                sel_vld = 1'b0;
  logic [1:0]          sel_id = '0;
  logic                sel_err;
  logic                cancel = 1'b0;
  logic [NUM_PROD-1:0] empty = '0;
  logic [CREDIT_W-1:0] credit;
  logic                disp_req;
  logic [1:0]          disp_id;
  logic                disp_ack = 1'b0;
  logic                chg_req;
  logic [CREDIT_W-1:0] chg_amt;
  logic                chg_ack = 1'b0;
  logic                busy;

  vend_sequencer #(
    .NUM_PROD    (NUM_PROD),
    .CREDIT_W    (CREDIT_W),
    .PRICE_VEC   (32'h140F0A05),
    .MAX_CREDIT  (MAX_CREDIT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .coin_vld (coin_vld),
    .coin_val (coin_val),
    .coin_rej (coin_rej),
    .sel_vld  (sel_vld),
    .sel_id   (sel_id),
    .sel_err  (sel_err),
    .cancel   (cancel),
    .empty    (empty),
    .credit   (credit),
    .disp_req (disp_req),
    .disp_id  (disp_id),
    .disp_ack (disp_ack),
    .chg_req  (chg_req),
    .chg_amt  (chg_amt),
    .chg_ack  (chg_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  int     price [NUM_PROD] = '{5, 10, 15, 20};
  phase_t m_ph;
  int     m_credit, m_did, m_camt, m_idle;
  bit     m_rej, m_err, m_dreq, m_creq;

  int n_pass  = 0;
  int n_total = 0;

  logic [5:0] coin_tbl [8] = '{6'd5, 6'd10, 6'd20, 6'd5, 6'd10, 6'd20, 6'd7, 6'd63};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ph = P_WAIT; m_credit = 0; m_did = 0; m_camt = 0; m_idle = 0;
    m_rej = 0; m_err = 0; m_dreq = 0; m_creq = 0;
  endtask

  // Refund the whole credit through the change hopper.
  task automatic model_refund();
    m_camt = m_credit; m_credit = 0; m_creq = 1; m_ph = P_REFUND;
  endtask

  // Applies the vending rules to the inputs present at this clock edge.
  task automatic model_edge();
    int cv;
    bit fits, tmo, sel_good;
    cv   = int'(coin_val);
    fits = (cv == 5 || cv == 10 || cv == 20) && (m_credit + cv <= MAX_CREDIT);
    sel_good = sel_vld && (int'(sel_id) < NUM_PROD) && !empty[sel_id] &&
               (m_credit >= price[sel_id]);
    m_rej = 0; m_err = 0; tmo = 0;
`ifdef VEND_TIMEOUT_EN
    if (m_ph == P_HAVE && !(coin_vld || sel_vld || cancel)) begin
      m_idle++;
      if (m_idle == TMO) begin tmo = 1; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
`endif
    case (m_ph)
      P_WAIT: begin
        if (coin_vld && fits) begin m_credit += cv; m_ph = P_HAVE; end
        else if (coin_vld) m_rej = 1;
        m_err = sel_vld;
      end
      P_HAVE: begin
        if (cancel || tmo) begin
          model_refund(); m_rej = coin_vld;
        end else if (sel_good) begin
          m_credit -= price[sel_id]; m_did = int'(sel_id); m_dreq = 1;
          m_ph = P_VEND; m_rej = coin_vld;
        end else begin
          m_err = sel_vld;
          if (coin_vld && fits) m_credit += cv;
          else if (coin_vld) m_rej = 1;
        end
      end
      P_VEND: begin
        m_rej = coin_vld;
        if (disp_ack) begin
          m_dreq = 0;
          if (m_credit > 0) model_refund();
          else m_ph = P_WAIT;
        end
      end
      P_REFUND: begin
        m_rej = coin_vld;
        if (chg_ack) begin m_creq = 0; m_camt = 0; m_ph = P_WAIT; end
      end
    endcase
  endtask

  task automatic check_outputs(input string t);
    check({t, ".credit"},   32'(credit),   32'(m_credit));
    check({t, ".coin_rej"}, 32'(coin_rej), 32'(m_rej));
    check({t, ".sel_err"},  32'(sel_err),  32'(m_err));
    check({t, ".disp_req"}, 32'(disp_req), 32'(m_dreq));
    check({t, ".chg_req"},  32'(chg_req),  32'(m_creq));
    check({t, ".chg_amt"},  32'(chg_amt),  32'(m_camt));
    check({t, ".busy"},     32'(busy),     32'(m_ph == P_VEND || m_ph == P_REFUND));
    if (m_dreq) check({t, ".disp_id"}, 32'(disp_id), 32'(m_did));
  endtask

  // One clock: model the edge, sample 1 time unit later, then drop strobes.
  task automatic tick(input string t);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(t);
    coin_vld = 1'b0; sel_vld = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic apply_reset(input string t);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(t);
    check({t, ".disp_id"}, 32'(disp_id), 32'd0);
    @(posedge clk);
    #1;
    check_outputs(t);
    rst = 1'b0;
  endtask

  task automatic coin(input int v, input string t);
    coin_vld = 1'b1; coin_val = 6'(v); tick(t);
  endtask

  task automatic sel(input int id, input string t);
    sel_vld = 1'b1; sel_id = 2'(id); tick(t);
  endtask

  initial begin
    model_reset();
    #2;
    apply_reset("reset");

    // 1: exact payment, no change
    coin(20, "t1.coin");
    sel(3, "t1.sel");
    check("t1.disp_req", 32'(disp_req), 32'd1);
    check("t1.disp_id",  32'(disp_id),  32'd3);
    check("t1.credit",   32'(credit),   32'd0);
    tick("t1.hold");
    disp_ack = 1'b1; tick("t1.ack");
    tick("t1.idle");
    check("t1.no_chg", 32'(chg_req), 32'd0);

    // 2: dispense with change
    coin(5, "t2.c5");
    coin(10, "t2.c10");
    check("t2.credit15", 32'(credit), 32'd15);
    sel(1, "t2.sel");
    check("t2.credit5", 32'(credit), 32'd5);
    disp_ack = 1'b1; tick("t2.dack");
    check("t2.chg_req", 32'(chg_req), 32'd1);
    check("t2.chg_amt", 32'(chg_amt), 32'd5);
    tick("t2.hold");
    chg_ack = 1'b1; tick("t2.cack");
    check("t2.done", 32'(busy), 32'd0);

    // 3: insufficient credit, then cancel
    coin(5, "t3.c5");
    sel(2, "t3.sel");
    check("t3.sel_err", 32'(sel_err), 32'd1);
    check("t3.credit",  32'(credit),  32'd5);
    tick("t3.pulse");
    check("t3.sel_err_drop", 32'(sel_err), 32'd0);
    cancel = 1'b1; tick("t3.cancel");
    check("t3.chg_amt", 32'(chg_amt), 32'd5);
    chg_ack = 1'b1; tick("t3.cack");

    // 4: illegal coin and credit ceiling
    coin(7, "t4.c7");
    check("t4.rej7", 32'(coin_rej), 32'd1);
    coin(20, "t4.a"); coin(20, "t4.b"); coin(20, "t4.c"); coin(20, "t4.d");
    coin(10, "t4.e"); coin(5, "t4.f");
    coin(10, "t4.over");
    check("t4.rej_over", 32'(coin_rej), 32'd1);
    check("t4.credit95", 32'(credit), 32'd95);
    coin(5, "t4.max");
    check("t4.credit100", 32'(credit), 32'd100);
    cancel = 1'b1; tick("t4.cancel");
    chg_ack = 1'b1; tick("t4.cack");

    // 5: sold-out channel, coin while busy, reset mid-dispense
    empty = 4'b0100;
    coin(20, "t5.c20");
    sel(2, "t5.empty");
    check("t5.sel_err", 32'(sel_err), 32'd1);
    sel(3, "t5.sel");
    coin(5, "t5.busy_coin");
    check("t5.busy_rej", 32'(coin_rej), 32'd1);
    apply_reset("t5.rst");
    empty = '0;

`ifdef VEND_TIMEOUT_EN
    // 6: inactivity refund
    coin(10, "t6.c10");
    for (int i = 0; i < TMO - 1; i++) tick("t6.wait");
    check("t6.not_yet", 32'(chg_req), 32'd0);
    tick("t6.fire");
    check("t6.chg_req", 32'(chg_req), 32'd1);
    check("t6.chg_amt", 32'(chg_amt), 32'd10);
    chg_ack = 1'b1; tick("t6.cack");
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      coin_vld = ($urandom_range(0, 99) < 30);
      coin_val = coin_tbl[$urandom_range(0, 7)];
      sel_vld  = ($urandom_range(0, 99) < 20);
      sel_id   = 2'($urandom_range(0, 3));
      cancel   = !sel_vld && ($urandom_range(0, 99) < 4);
      disp_ack = ($urandom_range(0, 99) < 30);
      chg_ack  = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 49) == 0)
        empty = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      tick("rand");
      if ($urandom_range(0, 499) == 0) apply_reset("rand.rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
